// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data.
// Ports: clk/rst; i_* fetch req/done; d_* data req/done; mem_* memory side; err.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_done,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        err_q, err_d;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        force_i;
  logic        owner_req;

  // Fetch is forced in once data has won MAX_D_STREAK times in a row
  // while fetch was waiting.
  assign force_i = i_req && (streak_q == STREAK_MAX);

  // The current owner must keep its request up until its done.
  assign owner_req = (state_q == BUSY_I) ? i_req : d_req;

  always_comb begin
    state_d     = state_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    streak_d    = streak_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (d_req && !force_i) begin
          state_d     = BUSY_D;
          mem_en_d    = 1'b1;
          mem_wr_d    = d_wr;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          cnt_d       = 8'd0;
          if (!i_req) begin
            streak_d = 4'd0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
          end
          if (d_wr && d_addr[0]) begin
            err_d = 1'b1;
          end
        end else if (i_req) begin
          state_d     = BUSY_I;
          mem_en_d    = 1'b1;
          mem_wr_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = 16'h0000;
          cnt_d       = 8'd0;
          streak_d    = 4'd0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (!owner_req) begin
          err_d = 1'b1;
        end
        if (mem_done) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          // Abandon the access; a late mem_done lands in IDLE and is ignored.
          if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      err_q       <= 1'b0;
      streak_q    <= 4'd0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      streak_q    <= streak_d;
      cnt_q       <= cnt_d;
    end
  end

  assign i_done    = mem_done && (state_q == BUSY_I);
  assign d_done    = mem_done && (state_q == BUSY_D);
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule
